// File: rtl/pem_pkg.sv
// ============================================================================
// Module  : pem_pkg
// Purpose : Shared constants and reader state encoding for the PEM capture path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pem_pkg;

  localparam int DAT_W  = 16;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_e;

endpackage

`default_nettype wire

// File: rtl/pem_skid_fifo.sv
// ============================================================================
// Module  : pem_skid_fifo
// Purpose : Two-entry {dat,addr,last} FIFO absorbing the RAM read latency.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pem_skid_fifo #(
  parameter int DAT_W  = 16,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DAT_W-1:0]  i_dat,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_last,
  input  logic              i_pop,
  output logic [DAT_W-1:0]  o_dat,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last,
  output logic [1:0]        o_count
);

  logic [DAT_W-1:0]  r_dat  [2];
  logic [ADDR_W-1:0] r_addr [2];
  logic              r_last [2];
  logic              r_wp;
  logic              r_rp;
  logic [1:0]        r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign w_do_push = i_push && ((r_count != 2'd2) || i_pop);
  assign w_do_pop  = i_pop && (r_count != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dat[0]  <= '0;
      r_dat[1]  <= '0;
      r_addr[0] <= '0;
      r_addr[1] <= '0;
      r_last[0] <= 1'b0;
      r_last[1] <= 1'b0;
      r_wp      <= 1'b0;
      r_rp      <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_dat[r_wp]  <= i_dat;
        r_addr[r_wp] <= i_addr;
        r_last[r_wp] <= i_last;
        r_wp         <= ~r_wp;
      end
      if (w_do_pop) begin
        r_rp <= ~r_rp;
      end
      r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

  // Head entry is a register, so it stays stable while the consumer stalls.
  assign o_dat   = r_dat[r_rp];
  assign o_addr  = r_addr[r_rp];
  assign o_last  = r_last[r_rp];
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/pem_frame_reader.sv
// ============================================================================
// Module  : pem_frame_reader
// Purpose : Streams one captured PEM frame out of RAM and tracks its signed peak.
//           Peak tracking is built only when PEM_PEAK_SEARCH_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pem_frame_reader #(
  parameter int DAT_W  = pem_pkg::DAT_W,
  parameter int ADDR_W = pem_pkg::ADDR_W,
  parameter int DEPTH  = pem_pkg::DEPTH
) (
  input  logic              alg_clk,
  input  logic              alg_rst_n,
  input  logic              trig_search,
  input  logic [ADDR_W:0]   frame_len,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DAT_W-1:0]  ram_rd_dat,
  output logic [DAT_W-1:0]  out_dat,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [DAT_W-1:0]  peak_dat,
  output logic [ADDR_W-1:0] peak_addr,
  output logic              search_done,
  output logic              busy,
  output logic              trig_overrun
);

  import pem_pkg::*;

  localparam logic [ADDR_W:0] C_DEPTH_LEN = (ADDR_W+1)'(DEPTH);

  rd_state_e         r_state;
  rd_state_e         w_state_nxt;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_rd_cnt;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inf_addr;
  logic              r_inf_last;
  logic              r_overrun;
  logic [ADDR_W:0]   w_len_clamped;
  logic [1:0]        w_fifo_count;
  logic [2:0]        w_fill;
  logic              w_pop;
  logic              w_rd_en;
  logic              w_rd_last;
  logic              w_trig_ok;

  assign w_len_clamped = (frame_len > C_DEPTH_LEN) ? C_DEPTH_LEN : frame_len;
  assign w_trig_ok     = trig_search && (r_state == ST_IDLE);
  assign w_pop         = out_valid && out_ready;

  // Occupancy the FIFO will have once this cycle's pop and landing read settle;
  // counting the pop lets a read issue behind a draining beat with no bubble.
  assign w_fill    = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_en   = (r_state == ST_READ) && (w_fill < 3'd2);
  assign w_rd_last = (r_rd_cnt == (r_len - 1'b1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (trig_search) w_state_nxt = (w_len_clamped == '0) ? ST_DONE : ST_READ;
      ST_READ:  if (w_rd_en && w_rd_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if ((w_fifo_count == 2'd0) && !r_inflight) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge alg_clk or negedge alg_rst_n) begin
    if (!alg_rst_n) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_rd_cnt   <= '0;
      r_inflight <= 1'b0;
      r_inf_addr <= '0;
      r_inf_last <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_rd_en;
      r_inf_addr <= r_rd_cnt[ADDR_W-1:0];
      r_inf_last <= w_rd_last;
      if (w_trig_ok) begin
        r_len    <= w_len_clamped;
        r_rd_cnt <= '0;
      end else if (w_rd_en) begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end
      if (w_trig_ok) begin
        r_overrun <= 1'b0;
      end else if (trig_search) begin
        r_overrun <= 1'b1;
      end
    end
  end

  pem_skid_fifo #(
    .DAT_W  (DAT_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (alg_clk),
    .rst_n   (alg_rst_n),
    .i_push  (r_inflight),
    .i_dat   (ram_rd_dat),
    .i_addr  (r_inf_addr),
    .i_last  (r_inf_last),
    .i_pop   (w_pop),
    .o_dat   (out_dat),
    .o_addr  (out_addr),
    .o_last  (out_last),
    .o_count (w_fifo_count)
  );

  assign out_valid    = (w_fifo_count != 2'd0);
  assign ram_rd_en    = w_rd_en;
  assign ram_rd_addr  = r_rd_cnt[ADDR_W-1:0];
  assign search_done  = (r_state == ST_DONE);
  assign busy         = (r_state != ST_IDLE);
  assign trig_overrun = r_overrun;

`ifdef PEM_PEAK_SEARCH_EN
  logic              r_run_vld;
  logic [DAT_W-1:0]  r_run_dat;
  logic [ADDR_W-1:0] r_run_addr;
  logic [DAT_W-1:0]  r_peak_dat;
  logic [ADDR_W-1:0] r_peak_addr;

  // Strict greater-than keeps the lowest address on ties, since beats arrive in order.
  always_ff @(posedge alg_clk or negedge alg_rst_n) begin
    if (!alg_rst_n) begin
      r_run_vld   <= 1'b0;
      r_run_dat   <= '0;
      r_run_addr  <= '0;
      r_peak_dat  <= '0;
      r_peak_addr <= '0;
    end else begin
      if (w_trig_ok) begin
        r_run_vld  <= 1'b0;
        r_run_dat  <= '0;
        r_run_addr <= '0;
      end else if (w_pop && (!r_run_vld || ($signed(out_dat) > $signed(r_run_dat)))) begin
        r_run_vld  <= 1'b1;
        r_run_dat  <= out_dat;
        r_run_addr <= out_addr;
      end
      if (r_state == ST_DONE) begin
        r_peak_dat  <= r_run_dat;
        r_peak_addr <= r_run_addr;
      end
    end
  end

  assign peak_dat  = r_peak_dat;
  assign peak_addr = r_peak_addr;
`else
  assign peak_dat  = '0;
  assign peak_addr = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pem_frame_reader.sv
// ============================================================================
// Module  : tb_pem_frame_reader
// Purpose : Table-driven, randomized self-checking bench for pem_frame_reader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pem_frame_reader;

  localparam int DAT_W  = 16;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;

  logic              alg_clk = 1'b0;
  logic              alg_rst_n = 1'b0;
  logic              trig_search = 1'b0;
  logic [ADDR_W:0]   frame_len = '0;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DAT_W-1:0]  ram_rd_dat = '0;
  logic [DAT_W-1:0]  out_dat;
  logic [ADDR_W-1:0] out_addr;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              out_last;
  logic [DAT_W-1:0]  peak_dat;
  logic [ADDR_W-1:0] peak_addr;
  logic              search_done;
  logic              busy;
  logic              trig_overrun;

  pem_frame_reader dut (
    .alg_clk      (alg_clk),
    .alg_rst_n    (alg_rst_n),
    .trig_search  (trig_search),
    .frame_len    (frame_len),
    .ram_rd_en    (ram_rd_en),
    .ram_rd_addr  (ram_rd_addr),
    .ram_rd_dat   (ram_rd_dat),
    .out_dat      (out_dat),
    .out_addr     (out_addr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .peak_dat     (peak_dat),
    .peak_addr    (peak_addr),
    .search_done  (search_done),
    .busy         (busy),
    .trig_overrun (trig_overrun)
  );

  always #5 alg_clk = ~alg_clk;

  logic [DAT_W-1:0] mem [DEPTH];
  always @(posedge alg_clk) if (ram_rd_en) ram_rd_dat <= mem[ram_rd_addr];

  typedef struct {
    logic [DAT_W-1:0]  d;
    logic [ADDR_W-1:0] a;
    logic              l;
  } beat_t;

  typedef struct {
    int len;
    int pat;        // 0 ramp, 1 0x8000 with 0x7FFF at 40/70, 2 random, 3 constant 0xFFF0
    int rdy_rand;
    int overrun_at; // cycle at which a second trigger is pulsed, 0 = none
    int abort_at;   // beat count at which reset is asserted, 0 = none
    int exp_n;
    int fixed_pk;
    int exp_pk;
    int exp_pa;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    beat_t exp_q[$];
    beat_t b;
    int n, rd_cnt, beats, first_rd, first_vld, last_cyc, cyc, mx, m_addr;
    bit done, aborted, stalled;
    logic [DAT_W-1:0]  prev_d;
    logic [ADDR_W-1:0] prev_a;
    logic [DAT_W-1:0]  e_pk;
    logic [ADDR_W-1:0] e_pa;

    for (int i = 0; i < DEPTH; i++) begin
      case (v.pat)
        0:       mem[i] = DAT_W'(i);
        1:       mem[i] = (i == 40 || i == 70) ? 16'h7FFF : 16'h8000;
        2:       mem[i] = DAT_W'($urandom);
        default: mem[i] = 16'hFFF0;
      endcase
    end
    n = (v.len > DEPTH) ? DEPTH : v.len;
    for (int i = 0; i < n; i++) begin
      b.d = mem[i]; b.a = ADDR_W'(i); b.l = (i == n - 1);
      exp_q.push_back(b);
    end
    // Peak model: largest signed value, then the lowest address holding it.
    mx = 0; m_addr = 0;
    if (n > 0) begin
      mx = -32768;
      for (int i = 0; i < n; i++) if (int'($signed(mem[i])) > mx) mx = int'($signed(mem[i]));
      for (int i = n - 1; i >= 0; i--) if (int'($signed(mem[i])) == mx) m_addr = i;
    end
`ifdef PEM_PEAK_SEARCH_EN
    e_pk = v.fixed_pk ? DAT_W'(v.exp_pk) : DAT_W'(mx);
    e_pa = v.fixed_pk ? ADDR_W'(v.exp_pa) : ADDR_W'(m_addr);
`else
    e_pk = '0;
    e_pa = '0;
`endif

    out_ready = 1'b1;
    @(posedge alg_clk); #1;
    frame_len = (ADDR_W+1)'(v.len);
    trig_search = 1'b1;
    @(posedge alg_clk); #1;
    trig_search = 1'b0;

    rd_cnt = 0; beats = 0; first_rd = -1; first_vld = -1; last_cyc = -1;
    done = 0; aborted = 0; stalled = 0; prev_d = '0; prev_a = '0; cyc = 0;
    while (!done && !aborted && cyc < 4 * n + 50) begin
      @(negedge alg_clk);
      cyc++;
      out_ready   = v.rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      trig_search = (cyc == v.overrun_at);
      #1;
      if (cyc == 1) begin
        chk("busy_after_trig", 32'(busy), 32'd1);
        chk("overrun_clear_on_accept", 32'(trig_overrun), 32'd0);
      end
      if (ram_rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        chk("rd_addr", 32'(ram_rd_addr), 32'(rd_cnt));
        rd_cnt++;
      end
      if (out_valid && first_vld < 0) first_vld = cyc;
      if (stalled) begin
        chk("stall_valid_held", 32'(out_valid), 32'd1);
        chk("stall_dat_held", 32'({out_dat, out_addr}), 32'({prev_d, prev_a}));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 32'(out_addr), 32'hFFFF_FFFF);
        end else begin
          b = exp_q.pop_front();
          chk("beat_dat", 32'(out_dat), 32'(b.d));
          chk("beat_addr", 32'(out_addr), 32'(b.a));
          chk("beat_last", 32'(out_last), 32'(b.l));
        end
        beats++;
        last_cyc = cyc;
        if (v.abort_at > 0 && beats == v.abort_at) begin
          trig_search = 1'b0;
          alg_rst_n = 1'b0;
          #1;
          chk("reset_outputs_zero",
              32'({out_valid, ram_rd_en, busy, search_done, trig_overrun, out_last,
                   |out_dat, |out_addr, |peak_dat, |peak_addr}), 32'd0);
          @(posedge alg_clk); #1;
          alg_rst_n = 1'b1;
          aborted = 1;
        end
      end
      stalled = out_valid && !out_ready;
      prev_d = out_dat;
      prev_a = out_addr;
      if (search_done) done = 1;
    end
    if (aborted) return;

    chk("search_done_seen", 32'(done), 32'd1);
    chk("beat_count", 32'(beats), 32'(v.exp_n));
    chk("beats_missing", 32'(exp_q.size()), 32'd0);
    chk("read_count", 32'(rd_cnt), 32'(n));
    if (n > 0) begin
      chk("first_rd_en_latency", 32'(first_rd), 32'd1);
      chk("first_valid_latency", 32'(first_vld), 32'd3);
      if (!v.rdy_rand) chk("no_bubbles", 32'(last_cyc - first_vld), 32'(n - 1));
    end else begin
      chk("len0_no_reads", 32'(first_rd), 32'hFFFF_FFFF);
      chk("len0_done_latency_le2", 32'(cyc >= 1 && cyc <= 2), 32'd1);
    end

    @(negedge alg_clk);
    trig_search = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("done_is_pulse", 32'(search_done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("overrun_flag", 32'(trig_overrun), 32'(v.overrun_at > 0));
    chk("peak_dat", 32'(peak_dat), 32'(e_pk));
    chk("peak_addr", 32'(peak_addr), 32'(e_pa));
  endtask

  initial begin
    vec_t tbl[13];
    tbl[0]  = '{100, 0, 0,  0,  0, 100, 1, 99,         99};
    tbl[1]  = '{100, 0, 1,  0,  0, 100, 1, 99,         99};
    tbl[2]  = '{100, 1, 1,  0,  0, 100, 1, 32'h7FFF,   40};
    tbl[3]  = '{0,   0, 0,  0,  0, 0,   1, 0,          0};
    tbl[4]  = '{600, 0, 0,  0,  0, 512, 1, 511,        511};
    tbl[5]  = '{512, 2, 1,  0,  0, 512, 0, 0,          0};
    tbl[6]  = '{1,   2, 0,  0,  0, 1,   0, 0,          0};
    tbl[7]  = '{37,  3, 1,  0,  0, 37,  1, 32'hFFF0,   0};
    tbl[8]  = '{100, 0, 0,  20, 0, 100, 1, 99,         99};
    tbl[9]  = '{0,   0, 0,  1,  0, 0,   1, 0,          0};
    tbl[10] = '{100, 2, 0,  0,  0, 100, 0, 0,          0};
    tbl[11] = '{100, 0, 1,  0,  50, 0,  0, 0,          0};
    tbl[12] = '{100, 0, 0,  0,  0, 100, 1, 99,         99};

    #1;
    chk("reset_state",
        32'({out_valid, ram_rd_en, busy, search_done, trig_overrun, out_last,
             |out_dat, |out_addr, |peak_dat, |peak_addr, |ram_rd_addr}), 32'd0);
    repeat (2) @(posedge alg_clk);
    #1 alg_rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(tbl[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
